// File: rtl/irq_rr_arbiter_pkg.sv
// Shared constants and state type for the round-robin interrupt arbiter.
package irq_pkg;

    localparam int IRQ_NUM  = 32;
    localparam int IRQ_ID_W = 5;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        SERV
    } irq_state_t;

endpackage

// File: rtl/irq_rr_arbiter_if.sv
// Request/acknowledge/completion bundle between the interrupt arbiter and the core/CSR side.
interface irq_rr_arbiter_if;
    import irq_pkg::*;

    logic [IRQ_NUM-1:0] int_req_i;
    logic [IRQ_NUM-1:0] mie_i;
    logic               int_ack_i;
    logic               INT_RST_i;
    logic               INT_o;
    logic [IRQ_NUM-1:0] mcause_o;
    logic [IRQ_NUM-1:0] int_fin_o;
    logic               busy_o;

    // Core / CSR side drives requests and handshakes, observes the arbiter outputs.
    modport master (
        output int_req_i, mie_i, int_ack_i, INT_RST_i,
        input  INT_o, mcause_o, int_fin_o, busy_o
    );

    modport slave (
        input  int_req_i, mie_i, int_ack_i, INT_RST_i,
        output INT_o, mcause_o, int_fin_o, busy_o
    );

endinterface

// File: rtl/irq_rr_arbiter_rr_find_first.sv
// Rotating priority encoder: index of the first set bit of vec_i at or after start_i, wrapping at the top.
module rr_find_first
    import irq_pkg::*;
(
    input  logic [IRQ_NUM-1:0]  vec_i,
    input  logic [IRQ_ID_W-1:0] start_i,
    output logic                found_o,
    output logic [IRQ_ID_W-1:0] idx_o
);

    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    always_comb begin
        logic [IRQ_ID_W-1:0] k;
        found_o = 1'b0;
        idx_o   = '0;
        k       = '0;
        // Walk from the farthest offset down so the nearest hit to start_i is written last.
        for (int j = IRQ_NUM - 1; j >= 0; j--) begin
            k = start_i + IRQ_ID_W'(j);
            if (vec_i[k]) begin
                found_o = 1'b1;
                idx_o   = k;
            end
        end
    end

endmodule

// File: rtl/irq_rr_arbiter.sv
// Round-robin interrupt arbiter: grants one enabled pending source, waits for ack, then for handler completion.
module irq_rr_arbiter
    import irq_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    irq_rr_arbiter_if.slave  bus
);

    logic [IRQ_NUM-1:0]  pend;
    logic [IRQ_ID_W-1:0] search_start;
    logic                win_found;
    logic [IRQ_ID_W-1:0] win_idx;

    irq_state_t          state_q;
    logic [IRQ_ID_W-1:0] id_q;
    logic [IRQ_ID_W-1:0] ptr_q;
    logic                int_q;
    logic [IRQ_NUM-1:0]  fin_q;

    assign pend         = bus.int_req_i & bus.mie_i;
    assign search_start = ptr_q + IRQ_ID_W'(1);

    rr_find_first u_find (
        .vec_i   (pend),
        .start_i (search_start),
        .found_o (win_found),
        .idx_o   (win_idx)
    );

    // NOTE: sequential state uses non-blocking assignments; the fin_q default below is overridden by a later bit write.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            id_q    <= '0;
            ptr_q   <= '1;
            int_q   <= 1'b0;
            fin_q   <= '0;
        end else begin
            fin_q <= '0;
            case (state_q)
                IDLE: begin
                    if (win_found) begin
                        id_q    <= win_idx;
                        int_q   <= 1'b1;
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    // Ack takes priority over a request withdrawn in the same cycle.
                    if (bus.int_ack_i) begin
                        int_q   <= 1'b0;
                        state_q <= SERV;
                    end else if (!pend[id_q]) begin
                        int_q   <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                SERV: begin
                    if (bus.INT_RST_i) begin
                        fin_q[id_q] <= 1'b1;
                        ptr_q       <= id_q;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    int_q   <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.INT_o     = int_q;
    assign bus.mcause_o  = {{(IRQ_NUM - IRQ_ID_W){1'b0}}, id_q};
    assign bus.int_fin_o = fin_q;
    assign bus.busy_o    = (state_q != IDLE);

endmodule

// File: tb/tb_irq_rr_arbiter.sv
// Self-checking bench for irq_rr_arbiter: directed scenarios plus randomized traffic against a behavioural model.
module tb_irq_rr_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    irq_rr_arbiter_if bus ();

    irq_rr_arbiter dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: phase 0 = waiting, 1 = raised to core, 2 = handler running.
    int          m_phase;
    int          m_id;
    int          m_ptr;
    logic        m_int;
    logic [31:0] m_fin;

    function automatic int rr_pick(logic [31:0] p, int ptr);
        for (int k = 1; k <= 32; k++) begin
            int c = (ptr + k) % 32;
            if (p[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_step();
        logic [31:0] p;
        int w;
        p = bus.int_req_i & bus.mie_i;
        m_fin = '0;
        if (rst) begin
            m_phase = 0; m_id = 0; m_ptr = 31; m_int = 1'b0;
        end else if (m_phase == 0) begin
            w = rr_pick(p, m_ptr);
            if (w >= 0) begin
                m_id = w; m_phase = 1; m_int = 1'b1;
            end
        end else if (m_phase == 1) begin
            if (bus.int_ack_i) begin
                m_phase = 2; m_int = 1'b0;
            end else if (!p[m_id]) begin
                m_phase = 0; m_int = 1'b0;
            end
        end else begin
            if (bus.INT_RST_i) begin
                m_fin = 32'h1 << m_id; m_ptr = m_id; m_phase = 0;
            end
        end
    endtask

    function automatic logic [65:0] pk(logic i, logic b, logic [31:0] m, logic [31:0] f);
        return {i, b, m, f};
    endfunction

    function automatic logic [65:0] obs();
        return {bus.INT_o, bus.busy_o, bus.mcause_o, bus.int_fin_o};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        bus.int_req_i = '0; bus.mie_i = '0; bus.int_ack_i = 1'b0; bus.INT_RST_i = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic ack_pulse();
        bus.int_ack_i = 1'b1; tick(); bus.int_ack_i = 1'b0;
    endtask

    task automatic done_pulse();
        bus.INT_RST_i = 1'b1; tick(); bus.INT_RST_i = 1'b0;
    endtask

    task automatic test_reset();
        logic [65:0] e;
        #1;
        e = pk(0, 0, 0, 0); n_tests++;
        if (obs() !== e) begin n_fail++; $display("FAIL reset_async: got %h expected %h", obs(), e); end
        apply_reset();
        e = pk(0, 0, 0, 0); n_tests++;
        if (obs() !== e) begin n_fail++; $display("FAIL reset_state: got %h expected %h", obs(), e); end
        tick();
        e = pk(0, 0, 0, 0); n_tests++;
        if (obs() !== e) begin n_fail++; $display("FAIL reset_idle: got %h expected %h", obs(), e); end
    endtask

    task automatic test_basic();
        logic [65:0] e;
        apply_reset();
        bus.mie_i = '1; bus.int_req_i = 32'h0000_0011;
        tick();
        e = pk(1, 1, 0, 0); n_tests++;
        if (obs() !== e) begin n_fail++; $display("FAIL basic_grant0: got %h expected %h", obs(), e); end
        ack_pulse();
        e = pk(0, 1, 0, 0); n_tests++;
        if (obs() !== e) begin n_fail++; $display("FAIL basic_serv: got %h expected %h", obs(), e); end
        done_pulse();
        e = pk(0, 0, 0, 32'h1); n_tests++;
        if (obs() !== e) begin n_fail++; $display("FAIL basic_fin: got %h expected %h", obs(), e); end
        tick();
        e = pk(1, 1, 4, 0); n_tests++;
        if (obs() !== e) begin n_fail++; $display("FAIL basic_grant4: got %h expected %h", obs(), e); end
    endtask

    task automatic test_wrap();
        logic [65:0] e;
        apply_reset();
        bus.mie_i = '1; bus.int_req_i = 32'h4000_0000;
        tick();
        e = pk(1, 1, 30, 0); n_tests++;
        if (obs() !== e) begin n_fail++; $display("FAIL wrap_grant30: got %h expected %h", obs(), e); end
        ack_pulse();
        bus.int_req_i = 32'h8000_0001;
        done_pulse();
        e = pk(0, 0, 30, 32'h4000_0000); n_tests++;
        if (obs() !== e) begin n_fail++; $display("FAIL wrap_fin30: got %h expected %h", obs(), e); end
        tick();
        e = pk(1, 1, 31, 0); n_tests++;
        if (obs() !== e) begin n_fail++; $display("FAIL wrap_grant31: got %h expected %h", obs(), e); end
        ack_pulse();
        done_pulse();
        e = pk(0, 0, 31, 32'h8000_0000); n_tests++;
        if (obs() !== e) begin n_fail++; $display("FAIL wrap_fin31: got %h expected %h", obs(), e); end
        tick();
        e = pk(1, 1, 0, 0); n_tests++;
        if (obs() !== e) begin n_fail++; $display("FAIL wrap_grant0: got %h expected %h", obs(), e); end
    endtask

    task automatic test_withdraw();
        logic [65:0] e;
        apply_reset();
        bus.mie_i = '1; bus.int_req_i = (32'h1 << 5) | (32'h1 << 7);
        tick();
        e = pk(1, 1, 5, 0); n_tests++;
        if (obs() !== e) begin n_fail++; $display("FAIL withdraw_grant5: got %h expected %h", obs(), e); end
        tick(); tick(); tick();
        e = pk(1, 1, 5, 0); n_tests++;
        if (obs() !== e) begin n_fail++; $display("FAIL withdraw_hold: got %h expected %h", obs(), e); end
        bus.int_req_i = 32'h1 << 7;
        tick();
        e = pk(0, 0, 5, 0); n_tests++;
        if (obs() !== e) begin n_fail++; $display("FAIL withdraw_drop: got %h expected %h", obs(), e); end
        tick();
        e = pk(1, 1, 7, 0); n_tests++;
        if (obs() !== e) begin n_fail++; $display("FAIL withdraw_next7: got %h expected %h", obs(), e); end
    endtask

    task automatic test_mask();
        logic [65:0] e;
        apply_reset();
        bus.int_req_i = 32'h4; bus.mie_i = '0;
        for (int i = 0; i < 20; i++) begin
            tick();
            e = pk(0, 0, 0, 0); n_tests++;
            if (obs() !== e) begin n_fail++; $display("FAIL mask_quiet[%0d]: got %h expected %h", i, obs(), e); end
        end
        bus.mie_i = 32'h4;
        tick();
        e = pk(1, 1, 2, 0); n_tests++;
        if (obs() !== e) begin n_fail++; $display("FAIL mask_enable: got %h expected %h", obs(), e); end
    endtask

    task automatic test_reset_mid_serv();
        logic [65:0] e;
        apply_reset();
        bus.mie_i = '1; bus.int_req_i = 32'h1 << 9;
        tick();
        ack_pulse();
        e = pk(0, 1, 9, 0); n_tests++;
        if (obs() !== e) begin n_fail++; $display("FAIL rstserv_serv9: got %h expected %h", obs(), e); end
        #2;
        rst = 1'b1;
        #1;
        e = pk(0, 0, 0, 0); n_tests++;
        if (obs() !== e) begin n_fail++; $display("FAIL rstserv_immediate: got %h expected %h", obs(), e); end
        bus.INT_RST_i = 1'b1;
        tick();
        bus.INT_RST_i = 1'b0;
        e = pk(0, 0, 0, 0); n_tests++;
        if (obs() !== e) begin n_fail++; $display("FAIL rstserv_nofin: got %h expected %h", obs(), e); end
        rst = 1'b0;
        tick();
        e = pk(1, 1, 9, 0); n_tests++;
        if (obs() !== e) begin n_fail++; $display("FAIL rstserv_regrant9: got %h expected %h", obs(), e); end
    endtask

    task automatic test_back_to_back();
        logic [65:0] e;
        apply_reset();
        bus.mie_i = '1; bus.int_req_i = '0;
        done_pulse();
        e = pk(0, 0, 0, 0); n_tests++;
        if (obs() !== e) begin n_fail++; $display("FAIL spur_rst_idle: got %h expected %h", obs(), e); end
        bus.int_req_i = 32'h1 << 3;
        tick();
        done_pulse();
        e = pk(1, 1, 3, 0); n_tests++;
        if (obs() !== e) begin n_fail++; $display("FAIL spur_rst_req: got %h expected %h", obs(), e); end
        ack_pulse();
        ack_pulse();
        e = pk(0, 1, 3, 0); n_tests++;
        if (obs() !== e) begin n_fail++; $display("FAIL spur_ack_serv: got %h expected %h", obs(), e); end
        bus.mie_i = '0;
        tick();
        e = pk(0, 1, 3, 0); n_tests++;
        if (obs() !== e) begin n_fail++; $display("FAIL serv_ignores_pend: got %h expected %h", obs(), e); end
        bus.mie_i = '1;
        done_pulse();
        e = pk(0, 0, 3, 32'h8); n_tests++;
        if (obs() !== e) begin n_fail++; $display("FAIL b2b_fin3: got %h expected %h", obs(), e); end
        tick();
        e = pk(1, 1, 3, 0); n_tests++;
        if (obs() !== e) begin n_fail++; $display("FAIL b2b_regrant3: got %h expected %h", obs(), e); end
    endtask

    task automatic test_random();
        logic [65:0] e;
        int errs;
        errs = 0;
        apply_reset();
        bus.mie_i = '1;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0) bus.int_req_i = $urandom & $urandom & $urandom;
            if ($urandom_range(0, 15) == 0) bus.mie_i = $urandom | $urandom;
            bus.int_ack_i = ($urandom_range(0, 2) == 0);
            bus.INT_RST_i = ($urandom_range(0, 3) == 0);
            rst = ($urandom_range(0, 599) == 0);
            tick();
            e = pk(m_int, m_phase != 0, 32'(m_id), m_fin); n_tests++;
            if (obs() !== e) begin
                n_fail++;
                if (errs < 10) $display("FAIL random[%0d]: got %h expected %h", c, obs(), e);
                errs++;
            end
        end
        rst = 1'b0;
        bus.int_ack_i = 1'b0; bus.INT_RST_i = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.int_req_i = '0; bus.mie_i = '0; bus.int_ack_i = 1'b0; bus.INT_RST_i = 1'b0;
        m_phase = 0; m_id = 0; m_ptr = 31; m_int = 1'b0; m_fin = '0;
        test_reset();
        test_basic();
        test_wrap();
        test_withdraw();
        test_mask();
        test_reset_mid_serv();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/irq_rr_arbiter.md
IRQ_RR_ARBITER -- requirements
Module: irq_rr_arbiter

Interface
REQ-001 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-002 rst_i  input  1  asynchronous, active-high reset.
REQ-003 int_req_i  input  32  level-sensitive interrupt request lines; bit i = source i.
REQ-004 mie_i  input  32  per-source enable mask from the CSR file.
REQ-005 int_ack_i  input  1  core has taken the trap; one-cycle pulse.
REQ-006 INT_RST_i  input  1  handler finished (mret); one-cycle pulse.
REQ-007 INT_o  output  1  interrupt request to core; registered.
REQ-008 mcause_o  output  32  {27'h0, granted source id}; registered.
REQ-009 int_fin_o  output  32  one-hot completion pulse to the finished source; registered.
REQ-010 busy_o  output  1  high in any state other than IDLE.

Function
REQ-011 pend = int_req_i & mie_i, evaluated combinationally every cycle.
REQ-012 Selection is round-robin: search starts at (ptr+1) mod 32, wraps past 31 to 0, and picks the first set bit of pend.
REQ-013 FSM states: IDLE, REQ, SERV; reset state IDLE.
REQ-014 IDLE: if pend != 0, register the winner into id and go to REQ; otherwise stay.
REQ-015 Latency: pend nonzero in IDLE at cycle N -> INT_o = 1 and mcause_o = id at cycle N+1.
REQ-016 REQ: INT_o = 1; on int_ack_i go to SERV.
REQ-017 REQ: if pend[id] = 0 and int_ack_i = 0 (withdrawn or masked), go to IDLE; INT_o = 0 next cycle; ptr unchanged; no int_fin_o.
REQ-018 REQ: int_ack_i together with pend[id] = 0 in the same cycle -> ack wins, go to SERV.
REQ-019 SERV: INT_o = 0; a change in pend has no effect; on INT_RST_i, int_fin_o[id] = 1 for exactly one cycle (next cycle), ptr <= id, go to IDLE.
REQ-020 INT_RST_i in IDLE or REQ and int_ack_i in IDLE or SERV are ignored.
REQ-021 Minimum turnaround: next INT_o rise is no earlier than 2 cycles after the INT_RST_i cycle.
REQ-022 mcause_o is stable from REQ entry through SERV exit and holds the last granted id while in IDLE.
REQ-023 int_fin_o is all-zero except during the REQ-019 pulse and never has more than one bit set.
REQ-024 Single active source: the same id is re-granted after completion if it is still pending.

Reset
REQ-025 On rst_i: state = IDLE, INT_o = 0, mcause_o = 0, int_fin_o = 0, busy_o = 0, id = 0, ptr = 31 (first search starts at source 0).
REQ-026 rst_i asserted mid-REQ or mid-SERV aborts immediately with no int_fin_o pulse.

Structure
REQ-027 Package irq_pkg holds IRQ_NUM = 32, IRQ_ID_W = 5, and the state enum typedef irq_state_t {IDLE, REQ, SERV}.
REQ-028 The combinational rotate-and-priority-encode logic is a sub-module rr_find_first (inputs: vector, start index; outputs: found, index).

Verification
REQ-029 After reset, int_req_i = 32'h0000_0011, mie_i = all-ones -> INT_o = 1 at the next cycle with mcause_o = 0; after ack then INT_RST_i, int_fin_o = 32'h1; the next grant is mcause_o = 4.
REQ-030 Wrap: ptr = 30, pend = 32'h8000_0001 -> grant 31; after completion, grant 0.
REQ-031 Withdrawal: grant 5 and hold in REQ, drop int_req_i[5] with no ack -> INT_o = 0 next cycle, no int_fin_o pulse; pending source 7 is granted next.
REQ-032 Masking: int_req_i = 32'h4, mie_i = 0 -> INT_o stays 0 for 20 cycles; set mie_i[2] -> INT_o = 1 next cycle with mcause_o = 2.
REQ-033 Reset mid-SERV with id = 9 -> all outputs are zero immediately and no int_fin_o[9] pulse occurs; the request still pending after reset is granted again as 9.
REQ-034 Spurious INT_RST_i in IDLE and stray int_ack_i in SERV -> no state change and no int_fin_o pulse.
